// File: rtl/tbird_pkg.sv
// Shared debounce state encoding and default timing constants for the
// Thunderbird input conditioning stage.
package tbird_pkg;

   typedef enum logic [1:0] {
      DB_LOW  = 2'b00,
      DB_RISE = 2'b01,
      DB_HIGH = 2'b10,
      DB_FALL = 2'b11
   } db_state_t;

   localparam int DB_CYCLES_DEF = 4;
   localparam int STEP_DIV_DEF  = 8;

   // Debounced level implied by a state: high while settled high or while a fall is pending.
   function automatic logic db_level(input db_state_t s);
      return (s == DB_HIGH) || (s == DB_FALL);
   endfunction

endpackage

// File: rtl/tbird_debounce.sv
// One switch channel: 2-flop synchronizer followed by a counting debounce FSM
// whose level output changes only after DB_CYCLES consecutive equal samples.
module tbird_debounce
   import tbird_pkg::*;
#(
   parameter int DB_CYCLES = DB_CYCLES_DEF
)
(
   input  logic clk,
   input  logic clr,
   input  logic sw_i,
   output logic level_o
);

   localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);

   logic          sync1_q;
   logic          sync2_q;
   db_state_t     state_q;
   logic [CW-1:0] cnt_q;
   logic          level_q;

   always_ff @(posedge clk) begin
      if (clr) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         state_q <= DB_LOW;
         cnt_q   <= '0;
         level_q <= 1'b0;
      end else begin
         sync1_q <= sw_i;
         sync2_q <= sync1_q;
         unique case (state_q)
            DB_LOW: begin
               if (sync2_q) begin
                  state_q <= DB_RISE;
                  cnt_q   <= CNT_ONE;
               end
            end
            DB_RISE: begin
               if (!sync2_q) begin
                  state_q <= DB_LOW;
                  cnt_q   <= '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_q <= DB_HIGH;
                  cnt_q   <= '0;
                  level_q <= db_level(DB_HIGH);
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
            DB_HIGH: begin
               if (!sync2_q) begin
                  state_q <= DB_FALL;
                  cnt_q   <= CNT_ONE;
               end
            end
            DB_FALL: begin
               if (sync2_q) begin
                  state_q <= DB_HIGH;
                  cnt_q   <= '0;
               end else if (cnt_q == CNT_LAST) begin
                  state_q <= DB_LOW;
                  cnt_q   <= '0;
                  level_q <= db_level(DB_LOW);
               end else begin
                  cnt_q <= cnt_q + CNT_ONE;
               end
            end
         endcase
      end
   end

   assign level_o = level_q;

endmodule

// File: rtl/tbird_input_cond.sv
// Turns raw left/right/hazard switches into mutually exclusive registered requests
// and paces the downstream light FSM with a periodic one-cycle step pulse.
module tbird_input_cond
   import tbird_pkg::*;
#(
   parameter int DB_CYCLES = DB_CYCLES_DEF,
   parameter int STEP_DIV  = STEP_DIV_DEF
)
(
   input  logic clk,
   input  logic clr,
   input  logic left_sw,
   input  logic right_sw,
   input  logic haz_sw,
   output logic left,
   output logic right,
   output logic haz,
   output logic step
);

   localparam int DW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [DW-1:0] DIV_LAST = DW'(STEP_DIV - 1);
   localparam logic [DW-1:0] DIV_ONE  = DW'(1);

   // Channel order: 0 = left, 1 = right, 2 = hazard.
   logic [2:0] sw_raw;
   logic [2:0] lvl;

   assign sw_raw = {haz_sw, right_sw, left_sw};

   generate
      for (genvar gi = 0; gi < 3; gi++) begin : g_db
         tbird_debounce #(
            .DB_CYCLES(DB_CYCLES)
         ) u_db (
            .clk     (clk),
            .clr     (clr),
            .sw_i    (sw_raw[gi]),
            .level_o (lvl[gi])
         );
      end
   endgenerate

   logic          left_q,  left_d;
   logic          right_q, right_d;
   logic          haz_q,   haz_d;
   logic          step_q,  step_d;
   logic [DW-1:0] div_q,   div_d;
   logic          restart;

   always_comb begin
      haz_d   = lvl[2] | (lvl[0] & lvl[1]);
      left_d  = lvl[0] & ~lvl[1] & ~lvl[2];
      right_d = lvl[1] & ~lvl[0] & ~lvl[2];
      // A fresh request from idle realigns the step phase so the light FSM starts promptly.
      restart = ({left_q, right_q, haz_q} == 3'b000) && ({left_d, right_d, haz_d} != 3'b000);
      if (restart) begin
         div_d  = '0;
         step_d = 1'b0;
      end else begin
         step_d = (div_q == DIV_LAST);
         div_d  = (div_q == DIV_LAST) ? '0 : div_q + DIV_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (clr) begin
         left_q  <= 1'b0;
         right_q <= 1'b0;
         haz_q   <= 1'b0;
         step_q  <= 1'b0;
         div_q   <= '0;
      end else begin
         left_q  <= left_d;
         right_q <= right_d;
         haz_q   <= haz_d;
         step_q  <= step_d;
         div_q   <= div_d;
      end
   end

   assign left  = left_q;
   assign right = right_q;
   assign haz   = haz_q;
   assign step  = step_q;

endmodule

// File: doc/tbird_input_cond.md
# tbird_input_cond

Input conditioning stage for the Thunderbird tail-light controller. It takes the raw asynchronous `left`/`right`/`haz` dashboard switches, then synchronizes, debounces and qualifies them into mutually exclusive clean requests. It also generates the one-cycle `step` pulse that paces the downstream light-sequence FSM. It sits directly upstream of `t_bird_control`.

## Interface
- `DB_CYCLES`, default 4: consecutive stable synchronized samples required to change a debounced level; minimum 2.
- `STEP_DIV`, default 8: clock cycles per `step` pulse; minimum 2.
- `clk` in 1: single clock; all state updates on its rising edge.
- `clr` in 1: reset, synchronous and active-high.
- `left_sw`, `right_sw`, `haz_sw` in 1 each: raw switch inputs; asynchronous and may bounce.
- `left`, `right`, `haz` out 1 each: qualified requests, registered; at most one is high at any time.
- `step` out 1: one-cycle advance pulse for the downstream FSM, registered.

## Operation
- **Per input channel:** a 2-flop synchronizer feeds a debounce FSM with a counter of width `$clog2(DB_CYCLES)`.
- **Debounce states:**
  - `DB_LOW`:
    - sync=1 -> `DB_RISE`, cnt=1.
  - `DB_RISE`:
    - sync=0 -> `DB_LOW`, cnt=0.
    - sync=1 and cnt==`DB_CYCLES`-1 -> `DB_HIGH`, cnt=0.
    - otherwise cnt++.
  - `DB_HIGH`:
    - sync=0 -> `DB_FALL`, cnt=1.
  - `DB_FALL`:
    - sync=1 -> `DB_HIGH`, cnt=0.
    - sync=0 and cnt==`DB_CYCLES`-1 -> `DB_LOW`, cnt=0.
    - otherwise cnt++.
- **Debounced level:** 1 in `DB_HIGH` and `DB_FALL`, 0 in `DB_LOW` and `DB_RISE`.
- **Qualification (registered), from debounced levels L, R, H:**
  - `haz` <= H | (L & R).
  - `left` <= L & !R & !H.
  - `right` <= R & !L & !H.
- **Step divider:**
  - Counter `div` runs 0..`STEP_DIV`-1 and wraps.
  - `step` <= 1 on the edge where `div`==`STEP_DIV`-1; otherwise `step` <= 0.
- **Restart:** on the edge where {`left`,`right`,`haz`} goes from 000 to non-zero, the divider restarts: `div` <= 0 and `step` <= 0. Restart has priority over a terminal-count pulse on the same edge.
- **Request change without passing through 000** (e.g. `left` -> `haz`): no restart; the divider keeps running.

## Timing
- **Reset:** with `clr` high at an edge:
  - sync flops, `div` and all debounce counters <= 0.
  - debounce states <= `DB_LOW`.
  - `left`, `right`, `haz`, `step` <= 0.
  - `clr` mid-operation aborts everything; held inputs must fully re-qualify.
- **Assert latency:** a raw input that goes high before edge 0 and stays stable gives a qualified output high after edge `DB_CYCLES`+2 (edge 6 at defaults). Breakdown:
  - 2 edges synchronizer.
  - `DB_CYCLES` edges debounce.
  - 1 edge qualification register.
- **Deassert latency:** identical.
- **Glitch filtering:** any synchronized pulse or gap shorter than `DB_CYCLES` cycles never reaches the outputs.
- **Step period:** `step` is high for exactly 1 cycle every `STEP_DIV` cycles. After `clr` is released, the first pulse is visible after the `STEP_DIV`-th edge.
- **Step after restart:** after a restart edge, the next `step` is visible after exactly `STEP_DIV` further edges.
- **Simultaneous qualification:** L and R qualifying on the same edge produce `haz` only, never a one-cycle `left` or `right`.
- **Staggered qualification:** if L qualifies one cycle before R, `left` is high for that one cycle, then `haz`. This is allowed.

## Structure
- **Package `tbird_pkg`:**
  - `db_state_t` enum, logic [1:0]: `DB_LOW`=00, `DB_RISE`=01, `DB_HIGH`=10, `DB_FALL`=11.
  - Default constants for `DB_CYCLES` and `STEP_DIV`.
- **Sub-module `tbird_debounce`:** parameterized by `DB_CYCLES`; contains the synchronizer, debounce FSM and counter; instantiated 3 times.
- **Top level:** qualification registers, restart detect and step divider.

## Test plan
All scenarios use defaults (`DB_CYCLES`=4, `STEP_DIV`=8).
- **Reset:** `clr`=1 for 5 cycles with all switches=1 -> all outputs 0 throughout. Release `clr` -> `haz`=1 after edge 6 post-release; `left`=`right`=0.
- **Assert/deassert latency:** `left_sw` 0->1 before edge 0 and held -> `left`=1 after edge 6 and not earlier. Then `left_sw`->0 -> `left`=0 exactly 6 edges later.
- **Bounce filtering:** `left_sw` high 3 cycles, low 1, high 3, low -> `left` stays 0. Then high 4+ cycles -> `left`=1 at the normal latency.
- **Mutual exclusion:** `left_sw` and `right_sw` rise together -> `haz`=1, `left`=`right`=0 on every cycle. With `haz_sw`=1 and `left_sw`=1 -> only `haz`=1.
- **Step generation:** idle -> `step` pulses 1 cycle wide every 8 cycles. `right` rising from idle on the edge where `div`==7 -> no `step` on that edge, next `step` exactly 8 edges later.
- **Reset mid-operation:** `clr` pulsed for 1 cycle while `left`=1 and `left_sw` held -> `left`=0 and `step`=0 after that edge. `left` returns to 1 after edge 6 following `clr` deassertion.
